// File: rtl/fp6_block_accumulator_pkg.sv
// rtl/fp6_block_accumulator_pkg.sv - shared FP6 adder-tree word format, E8M0 scale type and FSM states
package fp6_block_accumulator_pkg;

    localparam int ADD_EXP_W     = 5;
    localparam int ADD_MAN_W     = 10;
    localparam int ADD_BIAS      = 15;
    localparam int ADD_DATAWIDTH = 1 + ADD_EXP_W + ADD_MAN_W;

    typedef struct packed {
        logic                 sign;
        logic [ADD_EXP_W-1:0] exp;
        logic [ADD_MAN_W-1:0] man;
    } add_word_t;

    typedef logic [7:0] e8m0_t;

    localparam e8m0_t E8M0_NAN = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/fp6_block_accumulator_if.sv
// rtl/fp6_block_accumulator_if.sv - beat input and result output handshake bundle
interface fp6_block_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    import fp6_block_accumulator_pkg::*;

    logic [ADD_DATAWIDTH-1:0] sum_data;
    logic                     sum_valid;
    logic                     sum_last;
    logic                     sum_ready;
    e8m0_t                    scale_a;
    e8m0_t                    scale_b;
    logic [ACC_W-1:0]         res_data;
    logic                     res_nan;
    logic [CNT_W-1:0]         res_beats;
    logic                     res_valid;
    logic                     res_ready;

    modport master (
        output sum_data, sum_valid, sum_last, scale_a, scale_b, res_ready,
        input  sum_ready, res_data, res_nan, res_beats, res_valid
    );

    modport slave (
        input  sum_data, sum_valid, sum_last, scale_a, scale_b, res_ready,
        output sum_ready, res_data, res_nan, res_beats, res_valid
    );

endinterface

// File: rtl/fp6_block_accumulator_decode.sv
// rtl/fp6_block_accumulator_decode.sv - stage D decode/scale/shift of one beat (clamp under FP6_ACC_SAT_EN)
module fp6_acc_decode
    import fp6_block_accumulator_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int ACC_FRAC = 16
) (
    input  add_word_t        word,
    input  e8m0_t            scale_a,
    input  e8m0_t            scale_b,
    output logic [ACC_W-1:0] value,
    output logic             nan
);

    // Shift range spans roughly -262..+275, so 12 signed bits are plenty.
    localparam int SH_W = 12;
    localparam logic [ACC_W-1:0] MAG_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic signed [SH_W-1:0] sh;
    logic [SH_W-1:0]        amt;
    logic [ACC_W-1:0]       mag_wide;
    logic [ACC_W-1:0]       shifted;
    logic [ACC_W-1:0]       mag_out;
    logic                   zero;

    // Combined exponent of word and both scales, then align {1,man} to the accumulator fraction.
    always_comb begin
        sh = SH_W'(word.exp) - SH_W'(ADD_BIAS) + SH_W'(scale_a) + SH_W'(scale_b)
           - SH_W'(254) + SH_W'(ACC_FRAC) - SH_W'(ADD_MAN_W);
        mag_wide = ACC_W'({1'b1, word.man});
        if (sh < 0) begin
            amt     = SH_W'(-sh);
            shifted = mag_wide >> amt;
        end else begin
            amt     = SH_W'(sh);
            shifted = mag_wide << amt;
        end
    end

`ifdef FP6_ACC_SAT_EN
    // The leading one lands at bit ADD_MAN_W+sh; at or above the sign bit the magnitude overflows.
    logic ovf;
    assign ovf     = !sh[SH_W-1] && (sh >= $signed(SH_W'(ACC_W - 1 - ADD_MAN_W)));
    assign mag_out = ovf ? MAG_MAX : shifted;
`else
    assign mag_out = shifted;
`endif

    assign zero  = (word.exp == '0);
    assign nan   = (word.exp == '1) || (scale_a == E8M0_NAN) || (scale_b == E8M0_NAN);
    assign value = (zero || nan) ? '0 : (word.sign ? (~mag_out + 1'b1) : mag_out);

endmodule

// File: rtl/fp6_block_accumulator.sv
// rtl/fp6_block_accumulator.sv - scaled FP6 partial accumulator, two-stage pipe (FP6_ACC_SAT_EN selects saturating add)
module fp6_block_accumulator
    import fp6_block_accumulator_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int ACC_FRAC = 16,
    parameter int CNT_W    = 16
) (
    input logic clk,
    input logic rst,
    fp6_block_accumulator_if.slave bus
);

`ifdef FP6_ACC_SAT_EN
    localparam int SUM_W = ACC_W + 1;
`else
    localparam int SUM_W = ACC_W;
`endif
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

    logic             en;
    logic [ACC_W-1:0] dec_value;
    logic             dec_nan;

    logic             d_valid;
    logic             d_last;
    logic [ACC_W-1:0] d_value;
    logic             d_nan;

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             nan_q, nan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             beat;
    logic             load_res;
    logic [ACC_W-1:0] base;
    logic [SUM_W-1:0] wide;
    logic [ACC_W-1:0] sum_sat;
    logic             beat_nan;
    logic [CNT_W-1:0] beat_cnt;

    logic [ACC_W-1:0] res_data_q;
    logic             res_nan_q;
    logic [CNT_W-1:0] res_beats_q;
    logic             res_valid_q;

    // The whole pipe freezes only while a result is held without being taken.
    assign en            = ~(res_valid_q & ~bus.res_ready);
    assign bus.sum_ready = en & ~rst;

    fp6_acc_decode #(
        .ACC_W   (ACC_W),
        .ACC_FRAC(ACC_FRAC)
    ) u_decode (
        .word   (bus.sum_data),
        .scale_a(bus.scale_a),
        .scale_b(bus.scale_b),
        .value  (dec_value),
        .nan    (dec_nan)
    );

    // Stage D register: captures the decoded beat whenever the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid <= 1'b0;
            d_last  <= 1'b0;
            d_value <= '0;
            d_nan   <= 1'b0;
        end else if (en) begin
            d_valid <= bus.sum_valid;
            d_last  <= bus.sum_last;
            d_value <= dec_value;
            d_nan   <= dec_nan;
        end
    end

    // Stage A state register: FSM, running sum, sticky NaN and beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            nan_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            nan_q   <= nan_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage A next state: the first beat of a reduction loads, later beats add; a last beat retires.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        nan_d    = nan_q;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        beat     = en & d_valid;

        base     = (state_q == ST_IDLE) ? '0 : acc_q;
        wide     = SUM_W'($signed(base)) + SUM_W'($signed(d_value));
`ifdef FP6_ACC_SAT_EN
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum_sat = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = wide[ACC_W-1:0];
        end
`else
        sum_sat  = wide;
`endif
        beat_nan = d_nan | ((state_q == ST_ACCUM) & nan_q);
        if (state_q == ST_IDLE) begin
            beat_cnt = CNT_W'(1);
        end else begin
            beat_cnt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (beat && !d_last) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat && d_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat) begin
            if (d_last) begin
                load_res = 1'b1;
                acc_d    = '0;
                nan_d    = 1'b0;
                cnt_d    = '0;
            end else begin
                acc_d    = sum_sat;
                nan_d    = beat_nan;
                cnt_d    = beat_cnt;
            end
        end
    end

    // Result register: a new result may replace one being consumed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_nan_q   <= 1'b0;
            res_beats_q <= '0;
        end else if (en) begin
            res_valid_q <= load_res;
            if (load_res) begin
                res_data_q  <= sum_sat;
                res_nan_q   <= beat_nan;
                res_beats_q <= beat_cnt;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_nan   = res_nan_q;
    assign bus.res_beats = res_beats_q;

endmodule

// File: tb/tb_fp6_block_accumulator.sv
// tb/tb_fp6_block_accumulator.sv - table, corner-case and randomized checks against a value-level model
module tb_fp6_block_accumulator;
    import fp6_block_accumulator_pkg::*;

    localparam int ACC_W    = 32;
    localparam int ACC_FRAC = 16;
    localparam int CNT_W    = 16;
    localparam longint MAXV = 64'sd2147483647;

`ifdef FP6_ACC_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h8000_0001;
`else
    localparam logic [31:0] OVF_POS = 32'h0000_0000;
    localparam logic [31:0] OVF_NEG = 32'h0000_0000;
`endif

    typedef struct {
        logic [15:0] data;
        logic [7:0]  sa;
        logic [7:0]  sb;
        bit          last;
        logic [31:0] exp_data;
        bit          exp_nan;
        int          exp_beats;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        nan;
        int          beats;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp6_block_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    fp6_block_accumulator #(.ACC_W(ACC_W), .ACC_FRAC(ACC_FRAC), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int     n_vec = 0;
    int     n_bad = 0;
    res_t   exp_q[$];
    res_t   got_q[$];
    res_t   hist_q[$];
    vec_t   tbl[$];
    longint m_acc = 0;
    bit     m_nan = 1'b0;
    int     m_cnt = 0;
    bit     rnd_done = 1'b0;

    function automatic longint beat_value(input logic [15:0] w, input logic [7:0] sa, input logic [7:0] sb);
        int e, p;
        longint mag, v;
        e = int'(w[14:10]);
        if (e == 0 || e == 31 || sa == 8'hFF || sb == 8'hFF) return 0;
        p = e - 15 + int'(sa) + int'(sb) - 254 + ACC_FRAC - 10;
        mag = 1024 + longint'(w[9:0]);
        if (p < 0) begin
            v = (p < -40) ? 0 : mag / (longint'(1) << (-p));
        end else begin
`ifdef FP6_ACC_SAT_EN
            v = (p > 40 || (mag << p) > MAXV) ? MAXV : (mag << p);
`else
            v = (p >= 32) ? 0 : ((mag << p) & 64'hFFFF_FFFF);
`endif
        end
        if (w[15]) v = -v;
`ifndef FP6_ACC_SAT_EN
        v = longint'(int'(v));
`endif
        return v;
    endfunction

    function automatic bit beat_nan(input logic [15:0] w, input logic [7:0] sa, input logic [7:0] sb);
        return (w[14:10] == 5'h1F) || (sa == 8'hFF) || (sb == 8'hFF);
    endfunction

    function automatic longint acc_add(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef FP6_ACC_SAT_EN
        if (s > MAXV) s = MAXV;
        if (s < -MAXV) s = -MAXV;
`else
        s = longint'(int'(s));
`endif
        return s;
    endfunction

    // Observer: feeds accepted beats to the model and records delivered results.
    always @(negedge clk) begin
        res_t r;
        longint v;
        if (rst) begin
            m_acc = 0;
            m_nan = 1'b0;
            m_cnt = 0;
        end else begin
            if (bus.sum_valid && bus.sum_ready) begin
                v = beat_value(bus.sum_data, bus.scale_a, bus.scale_b);
                if (m_cnt == 0) begin
                    m_acc = v;
                    m_nan = beat_nan(bus.sum_data, bus.scale_a, bus.scale_b);
                    m_cnt = 1;
                end else begin
                    m_acc = acc_add(m_acc, v);
                    m_nan = m_nan | beat_nan(bus.sum_data, bus.scale_a, bus.scale_b);
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
                if (bus.sum_last) begin
                    r.data  = m_acc[31:0];
                    r.nan   = m_nan;
                    r.beats = m_cnt;
                    exp_q.push_back(r);
                    m_acc = 0;
                    m_nan = 1'b0;
                    m_cnt = 0;
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                r.data  = bus.res_data;
                r.nan   = bus.res_nan;
                r.beats = int'(bus.res_beats);
                got_q.push_back(r);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [7:0] a, input logic [7:0] b, input bit last);
        int w;
        bit ok;
        w  = 0;
        ok = 1'b0;
        bus.sum_data  = d;
        bus.scale_a   = a;
        bus.scale_b   = b;
        bus.sum_last  = last;
        bus.sum_valid = 1'b1;
        while (!ok && w < 200) begin
            @(negedge clk);
            ok = bus.sum_ready;
            w++;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL beat_accept_timeout: got no sum_ready in %0d cycles required acceptance", w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        res_t g, e;
        w = 0;
        repeat (4) @(negedge clk);
        while (got_q.size() != exp_q.size() && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("result_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            hist_q.push_back(g);
            if (!e.nan) chk("model_data", 64'(g.data), 64'(e.data));
            chk("model_nan", 64'(g.nan), 64'(e.nan));
            chk("model_beats", 64'(g.beats), 64'(e.beats));
        end
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_exp [4];
        logic [15:0] d;
        logic [7:0]  a, b;
        res_t        g;

        rst = 1'b1;
        bus.sum_valid = 1'b0;
        bus.sum_data  = '0;
        bus.sum_last  = 1'b0;
        bus.scale_a   = '0;
        bus.scale_b   = '0;
        bus.res_ready = 1'b1;

        tbl.push_back('{16'h3C00, 8'd127, 8'd127, 1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'h3C00, 8'd127, 8'd127, 1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'h3C00, 8'd127, 8'd127, 1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'h3C00, 8'd127, 8'd127, 1'b1, 32'h0004_0000, 1'b0, 4});
        tbl.push_back('{16'h3C00, 8'd128, 8'd127, 1'b1, 32'h0002_0000, 1'b0, 1});
        tbl.push_back('{16'hBC00, 8'd126, 8'd127, 1'b1, 32'hFFFF_8000, 1'b0, 1});
        tbl.push_back('{16'h7C00, 8'd127, 8'd127, 1'b1, 32'h0, 1'b1, 1});
        tbl.push_back('{16'h3C00, 8'd127, 8'd127, 1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'h3C00, 8'd127, 8'hFF,  1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'h3C00, 8'd127, 8'd127, 1'b1, 32'h0, 1'b1, 3});
        tbl.push_back('{16'h7BFF, 8'd140, 8'd140, 1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'h7BFF, 8'd140, 8'd140, 1'b1, OVF_POS, 1'b0, 2});
        tbl.push_back('{16'hFBFF, 8'd140, 8'd140, 1'b1, OVF_NEG, 1'b0, 1});
        tbl.push_back('{16'h0400, 8'd127, 8'd127, 1'b1, 32'h0000_0004, 1'b0, 1});
        tbl.push_back('{16'h0400, 8'd100, 8'd127, 1'b1, 32'h0, 1'b0, 1});
        tbl.push_back('{16'h03FF, 8'd127, 8'd127, 1'b1, 32'h0, 1'b0, 1});
        tbl.push_back('{16'h3E00, 8'd127, 8'd127, 1'b0, 32'h0, 1'b0, 0});
        tbl.push_back('{16'hC000, 8'd127, 8'd127, 1'b1, 32'hFFFF_8000, 1'b0, 2});
        tbl.push_back('{16'h8401, 8'd127, 8'd127, 1'b1, 32'hFFFF_FFFC, 1'b0, 1});

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_sum_ready", 64'(bus.sum_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_res_nan", 64'(bus.res_nan), 64'd0);
        chk("rst_res_beats", 64'(bus.res_beats), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sum_ready", 64'(bus.sum_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: result valid exactly two cycles after the last beat is accepted.
        for (int i = 0; i < 4; i++) send_beat(16'h3C00, 8'd127, 8'd127, i == 3);
        bus.sum_valid = 1'b0;
        @(negedge clk);
        chk("latency_t1_valid", 64'(bus.res_valid), 64'd0);
        @(negedge clk);
        chk("latency_t2_valid", 64'(bus.res_valid), 64'd1);
        chk("ones_data", 64'(bus.res_data), 64'h0004_0000);
        chk("ones_beats", 64'(bus.res_beats), 64'd4);
        drain();

        // Table vectors, streamed back to back.
        hist_q.delete();
        for (int i = 0; i < tbl.size(); i++) send_beat(tbl[i].data, tbl[i].sa, tbl[i].sb, tbl[i].last);
        bus.sum_valid = 1'b0;
        drain();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].last) begin
                if (hist_q.size() == 0) begin
                    chk("tbl_missing", 64'd0, 64'd1);
                end else begin
                    g = hist_q.pop_front();
                    if (!tbl[i].exp_nan) chk("tbl_data", 64'(g.data), 64'(tbl[i].exp_data));
                    chk("tbl_nan", 64'(g.nan), 64'(tbl[i].exp_nan));
                    chk("tbl_beats", 64'(g.beats), 64'(tbl[i].exp_beats));
                end
            end
        end

        // Backpressure: one result held, three more reductions queued behind it.
        hist_q.delete();
        bp_exp[0] = 32'h0001_0000;
        bp_exp[1] = 32'h0002_0000;
        bp_exp[2] = 32'h0003_0000;
        bp_exp[3] = 32'h0004_0000;
        bus.res_ready = 1'b0;
        send_beat(16'h3C00, 8'd127, 8'd127, 1'b1);
        bus.sum_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                send_beat(16'h4000, 8'd127, 8'd127, 1'b1);
                send_beat(16'h4200, 8'd127, 8'd127, 1'b1);
                send_beat(16'h4400, 8'd127, 8'd127, 1'b1);
                bus.sum_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_sum_ready", 64'(bus.sum_ready), 64'd0);
                    chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
                    chk("bp_res_data", 64'(bus.res_data), 64'h0001_0000);
                end
                @(posedge clk);
                #1;
                bus.res_ready = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 4; i++) begin
            if (hist_q.size() > i) chk("bp_order", 64'(hist_q[i].data), 64'(bp_exp[i]));
            else chk("bp_missing", 64'd0, 64'd1);
        end

        // Reset mid-reduction, then a fresh single-beat reduction.
        hist_q.delete();
        send_beat(16'h3C00, 8'd127, 8'd127, 1'b0);
        send_beat(16'h3C00, 8'd127, 8'd127, 1'b0);
        bus.sum_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(16'h3C00, 8'd127, 8'd127, 1'b1);
        bus.sum_valid = 1'b0;
        drain();
        if (hist_q.size() == 1) begin
            chk("rst_mid_data", 64'(hist_q[0].data), 64'h0001_0000);
            chk("rst_mid_beats", 64'(hist_q[0].beats), 64'd1);
        end else begin
            chk("rst_mid_count", 64'(hist_q.size()), 64'd1);
        end

        // Randomized beats with random gaps and random result backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    d[15]    = 1'($urandom_range(0, 1));
                    d[14:10] = 5'($urandom_range(0, 31));
                    d[9:0]   = 10'($urandom);
                    a = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(118, 136));
                    b = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(118, 136));
                    if ((a == 8'hFF || b == 8'hFF) && d[14:10] == 5'd0) d[14:10] = 5'd1;
                    if ($urandom_range(0, 3) == 0) begin
                        bus.sum_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_beat(d, a, b, (i == 299) || ($urandom_range(0, 3) == 0));
                end
                bus.sum_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.res_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.res_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
